// File: rtl/digital_clock_rtc.sv
// rtl/digital_clock_rtc.sv - real-time clock with prescaler, time/alarm load and 12/24 h display
module digital_clock_rtc #(
  parameter logic [31:0] TICK_DIV = 32'd50000000
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  input  logic       alarm_wr,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_clr,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [4:0] disp_hours,
  output logic       pm,
  output logic       tick,
  output logic       set_ack,
  output logic       set_err,
  output logic       alarm
);

  logic [31:0] presc;
  logic [4:0]  al_h;
  logic [5:0]  al_m;
  logic        armed;
  logic        set_ok, alarm_ok, inc, match;
  logic [5:0]  n_sec, n_min;
  logic [4:0]  n_hr;

  assign set_ok   = set_valid && (set_hours <= 5'd23) && (set_minutes <= 6'd59) && (set_seconds <= 6'd59);
  // A simultaneous time load always shadows an alarm write.
  assign alarm_ok = alarm_wr && !set_valid && (alarm_hours <= 5'd23) && (alarm_minutes <= 6'd59);
  assign inc      = run && (presc == TICK_DIV - 32'd1);

  always_comb begin
    n_sec = seconds + 6'd1;
    n_min = minutes;
    n_hr  = hours;
    if (seconds == 6'd59) begin
      n_sec = 6'd0;
      n_min = minutes + 6'd1;
      if (minutes == 6'd59) begin
        n_min = 6'd0;
        n_hr  = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      end
    end
  end

  assign match = armed && inc && !set_ok && (n_sec == 6'd0) && (n_min == al_m) && (n_hr == al_h);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= 32'd0;
      seconds <= 6'd0;
      minutes <= 6'd0;
      hours   <= 5'd0;
      tick    <= 1'b0;
      set_ack <= 1'b0;
      set_err <= 1'b0;
      alarm   <= 1'b0;
      al_h    <= 5'd0;
      al_m    <= 6'd0;
      armed   <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (set_ok) begin
        seconds <= set_seconds;
        minutes <= set_minutes;
        hours   <= set_hours;
        presc   <= 32'd0;
      end else if (run) begin
        if (inc) begin
          presc   <= 32'd0;
          seconds <= n_sec;
          minutes <= n_min;
          hours   <= n_hr;
          tick    <= 1'b1;
        end else begin
          presc <= presc + 32'd1;
        end
      end
      if (alarm_ok) begin
        al_h  <= alarm_hours;
        al_m  <= alarm_minutes;
        armed <= 1'b1;
      end
      if (match)
        alarm <= 1'b1;
      else if (alarm_clr)
        alarm <= 1'b0;
      set_ack <= (set_ok && !alarm_wr) || alarm_ok;
      set_err <= (set_valid && (alarm_wr || !set_ok)) || (alarm_wr && !set_valid && !alarm_ok);
    end
  end

  always_comb begin
    disp_hours = hours;
    pm         = 1'b0;
    if (mode_12h) begin
      if (hours == 5'd0) begin
        disp_hours = 5'd12;
      end else if (hours >= 5'd12) begin
        pm = 1'b1;
        if (hours > 5'd12)
          disp_hours = hours - 5'd12;
      end
    end
  end

endmodule
